// File: rtl/batcharger_ctrl_fsm.sv
// Battery charge controller: trickle -> constant-current -> constant-voltage -> end sequencing
// with debounced transitions, a CV timeout and temperature/supply fault handling.
module batcharger_ctrl_fsm #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned DEB_N    = 4,
  parameter int unsigned TMR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vtok,
  input  logic [7:0]       vbat,
  input  logic [7:0]       ibat,
  input  logic [7:0]       tbat,
  input  logic [7:0]       vcutoff,
  input  logic [7:0]       vpreset,
  input  logic [7:0]       iend,
  input  logic [7:0]       tempmin,
  input  logic [7:0]       tempmax,
  input  logic [TMR_W-1:0] tmax,
  input  logic [7:0]       icc_cfg,
  input  logic [7:0]       itc_cfg,
  input  logic [7:0]       vcv_cfg,
  output logic             cc,
  output logic             tc,
  output logic             cv,
  output logic [7:0]       icc,
  output logic [7:0]       itc,
  output logic [7:0]       vcv,
  output logic [2:0]       state,
  output logic             fault
);

  localparam int unsigned DEB_W = $clog2(DEB_N + 1);
  localparam int unsigned PRE_W = $clog2(TICK_DIV + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_N - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TC    = 3'd1,
    S_CC    = 3'd2,
    S_CV    = 3'd3,
    S_END   = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [TMR_W-1:0] tick_q, tick_d;
  logic [7:0]       icc_q, icc_d;
  logic [7:0]       itc_q, itc_d;
  logic [7:0]       vcv_q, vcv_d;

  logic             tok;
  logic             charging;
  logic             cond;
  logic             illegal;
  state_e           exit_state;
  logic             deb_done;
  logic             tick_evt;
  logic [TMR_W-1:0] tick_inc;
  logic             timeout;

  assign tok      = (tbat >= tempmin) && (tbat <= tempmax) && vtok;
  assign charging = (state_q == S_TC) || (state_q == S_CC) || (state_q == S_CV);

  // CV timer: prescaler divides clk into ticks; the timeout fires on the edge the count reaches tmax.
  assign tick_evt = (state_q == S_CV) && (pre_q == PRE_LAST);
  assign tick_inc = (&tick_q) ? tick_q : tick_q + TMR_W'(1);
  assign timeout  = (state_q == S_CV) && (tmax != '0) &&
                    ((tick_q == tmax) || (tick_evt && (tick_inc == tmax)));

  always_comb begin
    cond       = 1'b0;
    exit_state = S_IDLE;
    illegal    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cond       = en && tok && (vbat < vpreset);
        exit_state = (vbat < vcutoff) ? S_TC : S_CC;
      end
      S_TC: begin
        cond       = (vbat >= vcutoff);
        exit_state = S_CC;
      end
      S_CC: begin
        cond       = (vbat >= vcv_q);
        exit_state = S_CV;
      end
      S_CV: begin
        cond       = (ibat <= iend);
        exit_state = S_END;
      end
      S_END: begin
        cond       = (vbat < vpreset);
        exit_state = S_IDLE;
      end
      S_FAULT: begin
        cond       = tok;
        exit_state = S_IDLE;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign deb_done = cond && (deb_q >= DEB_LAST);

  always_comb begin
    state_d = state_q;
    if (!en || illegal) begin
      state_d = S_IDLE;
    end else if (charging && !tok) begin
      state_d = S_FAULT;
    end else if (timeout) begin
      state_d = S_END;
    end else if (deb_done) begin
      state_d = exit_state;
    end
  end

  always_comb begin
    deb_d = deb_q;
    if ((state_d != state_q) || !cond) begin
      deb_d = '0;
    end else if (!(&deb_q)) begin
      deb_d = deb_q + DEB_W'(1);
    end
  end

  always_comb begin
    pre_d  = pre_q;
    tick_d = tick_q;
    if (state_q != S_CV) begin
      pre_d  = '0;
      tick_d = '0;
    end else if (tick_evt) begin
      pre_d  = '0;
      tick_d = tick_inc;
    end else begin
      pre_d  = pre_q + PRE_W'(1);
    end
  end

  // Targets are captured only when a charge starts, so cfg edits mid-charge have no effect.
  always_comb begin
    icc_d = icc_q;
    itc_d = itc_q;
    vcv_d = vcv_q;
    if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
      icc_d = icc_cfg;
      itc_d = itc_cfg;
      vcv_d = vcv_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      deb_q   <= '0;
      pre_q   <= '0;
      tick_q  <= '0;
      icc_q   <= '0;
      itc_q   <= '0;
      vcv_q   <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      icc_q   <= icc_d;
      itc_q   <= itc_d;
      vcv_q   <= vcv_d;
    end
  end

  assign state = state_q;
  assign tc    = (state_q == S_TC);
  assign cc    = (state_q == S_CC);
  assign cv    = (state_q == S_CV);
  assign fault = (state_q == S_FAULT);
  assign icc   = icc_q;
  assign itc   = itc_q;
  assign vcv   = vcv_q;

endmodule

// File: tb/tb_batcharger_ctrl_fsm.sv
// Scoreboard bench for batcharger_ctrl_fsm: a cycle-counting reference model queues the expected
// outputs for every edge and an independent monitor pops and compares them after the edge.
module tb_batcharger_ctrl_fsm;
  localparam int TICK_DIV = 10;
  localparam int DEB_N    = 4;
  localparam int TMR_W    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, en, vtok;
  logic [7:0]       vbat, ibat, tbat, vcutoff, vpreset, iend, tempmin, tempmax;
  logic [TMR_W-1:0] tmax;
  logic [7:0]       icc_cfg, itc_cfg, vcv_cfg;
  logic             cc, tc, cv, fault;
  logic [7:0]       icc, itc, vcv;
  logic [2:0]       state;

  batcharger_ctrl_fsm #(.TICK_DIV(TICK_DIV), .DEB_N(DEB_N), .TMR_W(TMR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .vtok(vtok), .vbat(vbat), .ibat(ibat), .tbat(tbat),
    .vcutoff(vcutoff), .vpreset(vpreset), .iend(iend), .tempmin(tempmin), .tempmax(tempmax),
    .tmax(tmax), .icc_cfg(icc_cfg), .itc_cfg(itc_cfg), .vcv_cfg(vcv_cfg),
    .cc(cc), .tc(tc), .cv(cv), .icc(icc), .itc(itc), .vcv(vcv), .state(state), .fault(fault)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       cc, tc, cv, flt;
    logic [7:0] icc, itc, vcv;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   edge_no = 0;

  // Reference model: state as a plain int, debounce as a run length, CV timer as elapsed cycles.
  int   m_state = 0;
  int   m_run = 0;
  int   m_cvc = 0;
  int   m_icc = 0, m_itc = 0, m_vcv = 0;

  function automatic void model_step();
    int nxt, tgt;
    bit tk, cnd;
    if (rst) begin
      m_state = 0; m_run = 0; m_cvc = 0;
      m_icc = 0; m_itc = 0; m_vcv = 0;
      return;
    end
    tk  = (tbat >= tempmin) && (tbat <= tempmax) && vtok;
    cnd = 1'b0;
    tgt = 0;
    case (m_state)
      0: begin cnd = en && tk && (vbat < vpreset); tgt = (vbat < vcutoff) ? 1 : 2; end
      1: begin cnd = (vbat >= vcutoff);            tgt = 2; end
      2: begin cnd = (int'(vbat) >= m_vcv);        tgt = 3; end
      3: begin cnd = (ibat <= iend);               tgt = 4; end
      4: begin cnd = (vbat < vpreset);             tgt = 0; end
      default: begin cnd = tk;                     tgt = 0; end
    endcase
    nxt = m_state;
    if (!en) nxt = 0;
    else if ((m_state >= 1) && (m_state <= 3) && !tk) nxt = 5;
    else if ((m_state == 3) && (tmax != 0) && (m_cvc + 1 == int'(tmax) * TICK_DIV)) nxt = 4;
    else if (cnd && (m_run + 1 >= DEB_N)) nxt = tgt;
    if (nxt != m_state) begin
      if (m_state == 0) begin
        m_icc = int'(icc_cfg); m_itc = int'(itc_cfg); m_vcv = int'(vcv_cfg);
      end
      m_run = 0;
      m_cvc = 0;
    end else begin
      m_run = cnd ? m_run + 1 : 0;
      if (m_state == 3) m_cvc = m_cvc + 1;
    end
    m_state = nxt;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.st  = 3'(m_state);
    o.cc  = (m_state == 2);
    o.tc  = (m_state == 1);
    o.cv  = (m_state == 3);
    o.flt = (m_state == 5);
    o.icc = 8'(m_icc);
    o.itc = 8'(m_itc);
    o.vcv = 8'(m_vcv);
    return o;
  endfunction

  // Stimulus: inputs set 1 time unit after posedge; model evaluated on the negedge before the edge.
  task automatic cycle();
    @(negedge clk);
    model_step();
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: one comparison per edge, one log line per state transition.
  initial begin : monitor
    obs_t e, a;
    logic [2:0] last_st;
    last_st = 3'd0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        edge_no++;
        e = exp_q.pop_front();
        a = '{st: state, cc: cc, tc: tc, cv: cv, flt: fault, icc: icc, itc: itc, vcv: vcv};
        checks++;
        if (a === e) passed++;
        else $display("FAIL outputs edge=%0d got st=%0d cc=%b tc=%b cv=%b flt=%b icc=%h itc=%h vcv=%h, want st=%0d cc=%b tc=%b cv=%b flt=%b icc=%h itc=%h vcv=%h",
                      edge_no, a.st, a.cc, a.tc, a.cv, a.flt, a.icc, a.itc, a.vcv,
                      e.st, e.cc, e.tc, e.cv, e.flt, e.icc, e.itc, e.vcv);
        if (a.st !== last_st)
          $display("edge %0d: state %0d -> %0d (icc=%h itc=%h vcv=%h)", edge_no, last_st, a.st, a.icc, a.itc, a.vcv);
        last_st = a.st;
      end
    end
  end

  initial begin : stimulus
    int d, v;
    rst = 1'b1; en = 1'b1; vtok = 1'b1;
    tempmin = 8'h20; tempmax = 8'hC0; tbat = 8'h60;
    icc_cfg = 8'h7F; itc_cfg = 8'h19; vcv_cfg = 8'hBC;
    vcutoff = 8'h99; vpreset = 8'hB2; iend = 8'h0C;
    vbat = 8'h8C; ibat = 8'h60; tmax = '0;
    run(2);
    rst = 1'b0;
    // Full charge sequence TC -> CC -> CV -> END
    run(6);
    vbat = 8'hA3; run(6);
    vbat = 8'hBC; run(6);
    ibat = 8'h0A; run(6);
    // Recharge, then debounce interrupted in TC
    ibat = 8'h60; vbat = 8'h98; run(10);
    vbat = 8'h99; run(3);
    vbat = 8'h98; run(1);
    vbat = 8'h99; run(6);
    // CV timeout at tmax=5 ticks
    tmax = 16'd5; vbat = 8'hBC; run(65);
    // Timeout disabled: stay in CV
    tmax = '0; vbat = 8'h98; run(10);
    vbat = 8'hBC; run(1010);
    // cfg change ignored mid-charge, then enable drop
    vcv_cfg = 8'hCC; run(5);
    en = 1'b0; run(1);
    en = 1'b1; run(3);
    vcv_cfg = 8'hBC; vbat = 8'h98; run(10);
    vbat = 8'hBC; run(12);
    // Reset while in CV
    rst = 1'b1; run(2);
    rst = 1'b0; vbat = 8'hA3; run(10);
    // Over-temperature in CC, then recovery at the inclusive limit
    tbat = 8'hC1; run(2);
    tbat = 8'hC0; run(8);
    tbat = 8'h60;

    // Randomized phase
    vbat = 8'h90;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 12) begin
        d = int'($urandom_range(0, 10)) - 5;
        v = int'(vbat) + d;
        if (v < 8'h80) v = 8'h80;
        if (v > 8'hE0) v = 8'hE0;
        vbat = 8'(v);
      end
      if ($urandom_range(0, 15) == 0) ibat = 8'($urandom_range(0, 48));
      if ($urandom_range(0, 399) == 0) tbat = ($urandom_range(0, 1) == 0) ? 8'h1F : 8'hC1;
      else if ((tbat != 8'h60) && ($urandom_range(0, 9) == 0)) tbat = 8'h60;
      en   = ($urandom_range(0, 499) != 0);
      vtok = ($urandom_range(0, 799) != 0);
      rst  = ($urandom_range(0, 1999) == 0);
      if ((m_state != 3) && ($urandom_range(0, 99) == 0)) tmax = TMR_W'($urandom_range(0, 8));
      if ((m_state == 0) && ($urandom_range(0, 199) == 0)) begin
        icc_cfg = 8'($urandom);
        itc_cfg = 8'($urandom);
        vcv_cfg = 8'($urandom_range(8'hB0, 8'hD0));
      end
      cycle();
    end
    rst = 1'b0;

    #20;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain got %0d pending entries, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
